do_funct_cfg_sequencer: RTL and testbench

Per-channel controller that applies new function/mode/level settings to one single-ended digital-out channel's function-select mux. Mode or function changes use a break-before-make sequence: force Disabled mode, wait a dead time, switch the function, wait a settle time, then restore the requested mode. This prevents runt pulses and top/bottom shoot-through at the output transistors. Sits between the DSP-facing register decode and the channel's async function mux.

---
 rtl/do_funct_cfg_sequencer_if.sv | 24 ++
 rtl/do_funct_cfg_sequencer.sv | 176 +++++++++++++++++
 tb/tb_do_funct_cfg_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/do_funct_cfg_sequencer_if.sv
// Config/status bundle between register decode and one DO channel sequencer.
// master: drives cfg_* ; slave: drives which_*, level, busy, done, cfg_err.
interface do_funct_cfg_sequencer_if;
   logic       cfg_wr;
   logic [3:0] cfg_function;
   logic [1:0] cfg_mode;
   logic       cfg_level;
   logic [3:0] which_function;
   logic [1:0] which_mode;
   logic       level;
   logic       busy;
   logic       done;
   logic       cfg_err;

   modport master (
      output cfg_wr, cfg_function, cfg_mode, cfg_level,
      input  which_function, which_mode, level, busy, done, cfg_err
   );

   modport slave (
      input  cfg_wr, cfg_function, cfg_mode, cfg_level,
      output which_function, which_mode, level, busy, done, cfg_err
   );
endinterface

// File: rtl/do_funct_cfg_sequencer.sv
// Break-before-make function/mode sequencer for one digital-out channel.
// Ports: xclk, reset (sync, active-high), cfg (slave: write in, mux out).
// Optional macro DO_SEQ_PENDING_EN: one-deep pending slot for busy writes.
module do_funct_cfg_sequencer #(
   parameter int unsigned DEAD_CYCLES   = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  MAX_FUNCT     = 4'hA
) (
   input logic                   xclk,
   input logic                   reset,
   do_funct_cfg_sequencer_if.slave cfg
);

   // Zero counts behave as one cycle.
   localparam logic [7:0] DEAD_LD =
      (DEAD_CYCLES == 0) ? 8'd0 : 8'(DEAD_CYCLES - 1);
   localparam logic [7:0] SETTLE_LD =
      (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, DISABLE, DEAD, SWITCH, SETTLE, ENABLE
   } state_t;

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] func_q, func_n;
   logic [1:0] mode_q, mode_n;
   logic       lvl_q, lvl_n;
   logic       done_q, done_n;
   logic       err_q, err_n;
   logic [3:0] sh_f, sh_f_n;
   logic [1:0] sh_m, sh_m_n;
   logic       sh_l, sh_l_n;

   logic       wr_ok;
   logic       t_v;
   logic [3:0] t_f;
   logic [1:0] t_m;
   logic       t_l;

`ifdef DO_SEQ_PENDING_EN
   logic       pd_v, pd_v_n;
   logic [3:0] pd_f, pd_f_n;
   logic [1:0] pd_m, pd_m_n;
   logic       pd_l, pd_l_n;
`endif

   assign wr_ok = cfg.cfg_wr && (cfg.cfg_function <= MAX_FUNCT);

   always_ff @(posedge xclk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         func_q <= 4'd0;
         mode_q <= 2'b11;
         lvl_q  <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         sh_f   <= 4'd0;
         sh_m   <= 2'b11;
         sh_l   <= 1'b0;
`ifdef DO_SEQ_PENDING_EN
         pd_v   <= 1'b0;
         pd_f   <= 4'd0;
         pd_m   <= 2'b11;
         pd_l   <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         func_q <= func_n;
         mode_q <= mode_n;
         lvl_q  <= lvl_n;
         done_q <= done_n;
         err_q  <= err_n;
         sh_f   <= sh_f_n;
         sh_m   <= sh_m_n;
         sh_l   <= sh_l_n;
`ifdef DO_SEQ_PENDING_EN
         pd_v   <= pd_v_n;
         pd_f   <= pd_f_n;
         pd_m   <= pd_m_n;
         pd_l   <= pd_l_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      func_n  = func_q;
      mode_n  = mode_q;
      lvl_n   = lvl_q;
      done_n  = 1'b0;
      err_n   = cfg.cfg_wr && !wr_ok;
      sh_f_n  = sh_f;
      sh_m_n  = sh_m;
      sh_l_n  = sh_l;
      t_v     = wr_ok;
      t_f     = cfg.cfg_function;
      t_m     = cfg.cfg_mode;
      t_l     = cfg.cfg_level;
`ifdef DO_SEQ_PENDING_EN
      pd_v_n  = pd_v;
      pd_f_n  = pd_f;
      pd_m_n  = pd_m;
      pd_l_n  = pd_l;
      // A parked write is served before a fresh one; the fresh
      // one is parked instead (or overwrites the slot while busy).
      if (state == IDLE && pd_v) begin
         t_v    = 1'b1;
         t_f    = pd_f;
         t_m    = pd_m;
         t_l    = pd_l;
         pd_v_n = 1'b0;
      end
      if (wr_ok && (state != IDLE || pd_v)) begin
         pd_v_n = 1'b1;
         pd_f_n = cfg.cfg_function;
         pd_m_n = cfg.cfg_mode;
         pd_l_n = cfg.cfg_level;
      end
`else
      if (state != IDLE && cfg.cfg_wr) err_n = 1'b1;
`endif

      unique case (state)
         IDLE: begin
            if (t_v) begin
               if (t_f == func_q && t_m == mode_q) begin
                  lvl_n  = t_l;
                  done_n = 1'b1;
               end else begin
                  sh_f_n  = t_f;
                  sh_m_n  = t_m;
                  sh_l_n  = t_l;
                  state_n = DISABLE;
               end
            end
         end
         DISABLE: begin
            mode_n  = 2'b11;
            cnt_n   = DEAD_LD;
            state_n = DEAD;
         end
         DEAD: begin
            if (cnt == 8'd0) state_n = SWITCH;
            else cnt_n = cnt - 8'd1;
         end
         SWITCH: begin
            func_n  = sh_f;
            lvl_n   = sh_l;
            cnt_n   = SETTLE_LD;
            state_n = SETTLE;
         end
         SETTLE: begin
            if (cnt == 8'd0) state_n = ENABLE;
            else cnt_n = cnt - 8'd1;
         end
         ENABLE: begin
            mode_n  = sh_m;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign cfg.which_function = func_q;
   assign cfg.which_mode     = mode_q;
   assign cfg.level          = lvl_q;
   assign cfg.busy           = (state != IDLE);
   assign cfg.done           = done_q;
   assign cfg.cfg_err        = err_q;

endmodule

// File: tb/tb_do_funct_cfg_sequencer.sv
// Directed bench for do_funct_cfg_sequencer (default parameters).
// Build with or without DO_SEQ_PENDING_EN to match the RTL build.
module tb_do_funct_cfg_sequencer;

   logic xclk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   do_funct_cfg_sequencer_if bus ();

   do_funct_cfg_sequencer dut (
      .xclk  (xclk),
      .reset (reset),
      .cfg   (bus.slave)
   );

   always #5 xclk = ~xclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle past it.
   task automatic tick();
      @(posedge xclk);
      #1;
   endtask

   task automatic wr(input logic [3:0] f, input logic [1:0] m,
                     input logic l);
      bus.cfg_wr       = 1'b1;
      bus.cfg_function = f;
      bus.cfg_mode     = m;
      bus.cfg_level    = l;
      tick();
      bus.cfg_wr       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.done), 32'd1);
   endtask

   initial begin
      int errs_seen;
      bus.cfg_wr       = 1'b0;
      bus.cfg_function = 4'd0;
      bus.cfg_mode     = 2'b00;
      bus.cfg_level    = 1'b0;
      reset            = 1'b1;
      #1;
      repeat (3) tick();
      chk("rst_mode", 32'(bus.which_mode), 32'h3);
      chk("rst_func", 32'(bus.which_function), 32'h0);
      chk("rst_level", 32'(bus.level), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_err", 32'(bus.cfg_err), 32'h0);
      reset = 1'b0;
      tick();

      // Full sequence: func 4, push-pull; done on edge 23 after write.
      wr(4'h4, 2'b00, 1'b0);
      chk("seq_busy0", 32'(bus.busy), 32'h1);
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (k < 23) chk("seq_mode_dis", 32'(bus.which_mode), 32'h3);
         if (k == 17) chk("seq_func17", 32'(bus.which_function), 32'h0);
         if (k == 18) chk("seq_func18", 32'(bus.which_function), 32'h4);
         if (k == 22) chk("seq_done22", 32'(bus.done), 32'h0);
         if (k == 23) begin
            chk("seq_mode23", 32'(bus.which_mode), 32'h0);
            chk("seq_done23", 32'(bus.done), 32'h1);
         end
      end
      tick();
      chk("seq_idle_busy", 32'(bus.busy), 32'h0);
      chk("seq_done_clr", 32'(bus.done), 32'h0);

      // Fast path: same func/mode, new level.
      wr(4'h4, 2'b00, 1'b1);
      chk("fast_level", 32'(bus.level), 32'h1);
      chk("fast_done", 32'(bus.done), 32'h1);
      chk("fast_busy", 32'(bus.busy), 32'h0);
      tick();
      chk("fast_done_clr", 32'(bus.done), 32'h0);
      chk("fast_busy2", 32'(bus.busy), 32'h0);

      // Invalid function code.
      wr(4'hB, 2'b01, 1'b0);
      chk("inv_err", 32'(bus.cfg_err), 32'h1);
      chk("inv_func", 32'(bus.which_function), 32'h4);
      chk("inv_mode", 32'(bus.which_mode), 32'h0);
      chk("inv_level", 32'(bus.level), 32'h1);
      chk("inv_busy", 32'(bus.busy), 32'h0);
      tick();
      chk("inv_err_clr", 32'(bus.cfg_err), 32'h0);

      // Reset while in SETTLE (edge 20 after write).
      wr(4'h2, 2'b01, 1'b0);
      repeat (20) tick();
      chk("mid_func_pre", 32'(bus.which_function), 32'h2);
      reset = 1'b1;
      tick();
      chk("mid_mode", 32'(bus.which_mode), 32'h3);
      chk("mid_func", 32'(bus.which_function), 32'h0);
      chk("mid_busy", 32'(bus.busy), 32'h0);
      chk("mid_done", 32'(bus.done), 32'h0);
      reset = 1'b0;
      tick();

      // Busy write: func A arrives at edge 5 of a running sequence.
      wr(4'h4, 2'b00, 1'b0);
      repeat (4) tick();
      wr(4'hA, 2'b00, 1'b1);
`ifdef DO_SEQ_PENDING_EN
      chk("busy_err_pend", 32'(bus.cfg_err), 32'h0);
`else
      chk("busy_err", 32'(bus.cfg_err), 32'h1);
`endif
      wait_done("busy_done1", 30);
      chk("busy_func1", 32'(bus.which_function), 32'h4);
      chk("busy_mode1", 32'(bus.which_mode), 32'h0);
      tick();
`ifdef DO_SEQ_PENDING_EN
      tick();
      chk("pend_busy2", 32'(bus.busy), 32'h1);
      wait_done("pend_done2", 40);
      chk("pend_func2", 32'(bus.which_function), 32'hA);
      chk("pend_mode2", 32'(bus.which_mode), 32'h0);
      chk("pend_level2", 32'(bus.level), 32'h1);
`else
      errs_seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) errs_seen++;
         tick();
      end
      chk("nopend_quiet", 32'(errs_seen), 32'h0);
      chk("nopend_func", 32'(bus.which_function), 32'h4);
      chk("nopend_level", 32'(bus.level), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
